// File: rtl/buffer_load_sequencer_pkg.sv
// Shared definitions for the feature buffer load sequencer: word width,
// sequencer state encoding and buffer load/hold control levels.
package buffer_load_sequencer_pkg;

    localparam int FEATURE_IN_WIDTH = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_FILL    = 2'd1,
        SEQ_PRESENT = 2'd2
    } seq_state_t;

    localparam logic BUF_LOAD = 1'b0;
    localparam logic BUF_HOLD = 1'b1;

endpackage

// File: rtl/buffer_load_sequencer.sv
// Fills NUM_BUF feature buffer registers from a valid/ready stream in index
// order, then presents the complete frame downstream and refills.
module buffer_load_sequencer
    import buffer_load_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = FEATURE_IN_WIDTH,
    parameter int NUM_BUF    = 8,
    parameter int IDX_W      = $clog2(NUM_BUF),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_buf_data,
    output logic [NUM_BUF-1:0]    o_buf_ctrl,
    output logic                  o_frame_valid,
    input  logic                  i_frame_ready,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_frame_count
);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] w_wr_idx_next;
    logic [CNT_W-1:0] r_frame_count;
    logic [CNT_W-1:0] w_frame_count_next;
    logic             w_last_slot;
    logic             w_fill_load;
    logic             w_in_ready;
    logic             w_frame_valid;
    logic             w_busy;

    assign w_last_slot = (r_wr_idx == IDX_W'(NUM_BUF - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SEQ_IDLE;
            r_wr_idx      <= '0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_wr_idx      <= w_wr_idx_next;
            r_frame_count <= w_frame_count_next;
        end
    end

    // abort overrides every transition, including a pending final accept or handshake
    always_comb begin
        w_state_next       = r_state;
        w_wr_idx_next      = r_wr_idx;
        w_frame_count_next = r_frame_count;
        if (i_abort) begin
            w_state_next  = SEQ_IDLE;
            w_wr_idx_next = '0;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (i_start) begin
                        w_state_next  = SEQ_FILL;
                        w_wr_idx_next = '0;
                    end
                end
                SEQ_FILL: begin
                    if (i_in_valid) begin
                        if (w_last_slot) begin
                            w_state_next  = SEQ_PRESENT;
                            w_wr_idx_next = '0;
                        end else begin
                            w_wr_idx_next = r_wr_idx + IDX_W'(1);
                        end
                    end
                end
                SEQ_PRESENT: begin
                    if (i_frame_ready) begin
                        w_frame_count_next = r_frame_count + CNT_W'(1);
                        w_state_next       = SEQ_FILL;
                        w_wr_idx_next      = '0;
                    end
                end
                default: begin
                    w_state_next  = SEQ_IDLE;
                    w_wr_idx_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_in_ready    = 1'b0;
        w_frame_valid = 1'b0;
        w_busy        = (r_state != SEQ_IDLE);
        w_fill_load   = 1'b0;
        case (r_state)
            SEQ_FILL: begin
                // a word offered during abort is neither accepted nor loaded
                w_in_ready  = !i_abort;
                w_fill_load = i_in_valid && !i_abort;
            end
            SEQ_PRESENT: w_frame_valid = 1'b1;
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_ctrl
            assign o_buf_ctrl[gi] = (w_fill_load && (r_wr_idx == IDX_W'(gi))) ? BUF_LOAD : BUF_HOLD;
        end
    endgenerate

    assign o_buf_data    = i_in_data;
    assign o_in_ready    = w_in_ready;
    assign o_frame_valid = w_frame_valid;
    assign o_busy        = w_busy;
    assign o_frame_count = r_frame_count;

endmodule

// File: doc/buffer_load_sequencer.md
Name: buffer_load_sequencer

Overview:
- Sequences a bank of NUM_BUF feature buffer registers. Each register loads when its control bit is 0 and holds when it is 1.
- Accepts a valid/ready feature stream and loads one buffer per accepted beat, in index order.
- Once all buffers are filled, presents the frame to the downstream TNN column with a valid/ready handshake, then refills.
- Sits between the input feature stream and the feature buffer bank. Drives their shared data bus and per-buffer load/hold controls.

Parameters:
- DATA_WIDTH, `FEATURE_IN_WIDTH (8), feature word width.
- NUM_BUF, 8, number of buffer registers sequenced; must be >= 2.
- IDX_W, $clog2(NUM_BUF), width of the write index.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; arms the sequencer from IDLE.
- abort  in  1  synchronous clear back to IDLE.
- in_data  in  DATA_WIDTH  stream feature word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- buf_data  out  DATA_WIDTH  shared data bus to all buffers.
- buf_ctrl  out  NUM_BUF  per-buffer control; 0 = load, 1 = hold.
- frame_valid  out  1  all buffers hold a complete frame.
- frame_ready  in  1  downstream has consumed the frame.
- busy  out  1  state != IDLE.
- frame_count  out  CNT_W  number of completed handshakes, wraps.

Behaviour:
- Reset (async): state=IDLE, wr_idx=0, frame_count=0, buf_ctrl=all 1s, frame_valid=0, in_ready=0, busy=0.
- buf_data = in_data, combinational pass-through.
- buf_ctrl is combinational from state, wr_idx and in_valid:
  - In FILL with in_valid=1: bit wr_idx = 0, all other bits = 1.
  - Otherwise: all bits = 1.
  - At most one bit is 0 in any cycle.
- States:
  - IDLE:
    - in_ready=0.
    - start=1 -> FILL with wr_idx=0.
  - FILL:
    - in_ready=1.
    - On accept (in_valid=1): wr_idx += 1.
    - Accept with wr_idx==NUM_BUF-1 -> PRESENT and wr_idx=0. The buffer holds the word after that same edge.
  - PRESENT:
    - in_ready=0, frame_valid=1, buf_ctrl=all 1s.
    - frame_valid rises on the first PRESENT cycle, exactly one cycle after the final load edge, so buffer outputs are already stable.
    - frame_ready=1 -> frame_count += 1 (wraps at 2^CNT_W), then FILL with wr_idx=0. The sequencer does not return to IDLE; it free-runs until abort.
    - frame_valid stays high, and buffer contents stay stable, until frame_ready arrives.
- Accept latency: word k of a frame is visible on buffer k's output one clock after its accept cycle.
- Frame latency: NUM_BUF accepted beats + 1 cycle to frame_valid.
- Gaps (in_valid=0) during FILL: wr_idx holds and all buffers hold.
- abort:
  - Highest priority in any state: next state IDLE, wr_idx=0, all controls hold.
  - frame_count is not cleared.
  - An abort in the same cycle as a final accept or a frame_ready handshake cancels that transition; frame_count is not incremented.
- start: ignored when state != IDLE. start and abort together -> IDLE.
- frame_ready outside PRESENT: ignored.
- Partially filled buffers after abort keep stale data; the sequencer does not clear them.
- Buffer register contents are reset by their own reset, not by this block.

Decomposition:
- Shared package/header (network_params.vh):
  - FEATURE_IN_WIDTH.
  - State encoding constants SEQ_IDLE=2'd0, SEQ_FILL=2'd1, SEQ_PRESENT=2'd2.
  - BUF_LOAD=1'b0, BUF_HOLD=1'b1.
- No sub-module needed in the sequencer itself. The testbench instantiates NUM_BUF feature buffer registers driven by buf_data/buf_ctrl to check end-to-end contents.

Test Plan:
1. Reset, then start, NUM_BUF=4, stream 0x11,0x22,0x33,0x44 back-to-back -> buf_ctrl = 1110, 1101, 1011, 0111 on the four accept cycles. frame_valid=1 on cycle 5. Buffers read 11/22/33/44. in_ready=0 while frame_valid=1.
2. Same stream with in_valid gaps (valid pattern 1,0,0,1,1,0,1) -> buf_ctrl=1111 on gap cycles. wr_idx holds. Final contents are unchanged from scenario 1.
3. Hold frame_ready=0 for 10 cycles in PRESENT while driving in_valid=1 with 0xFF -> frame_valid stays 1, buf_ctrl=1111, contents stay 11/22/33/44. Then frame_ready=1 -> frame_count=1, FILL, next word loads buffer 0.
4. abort after 2 accepts -> IDLE next cycle, busy=0, buf_ctrl=1111. A following start plus 4 words fills buffers from index 0.
5. abort coincident with the frame_ready handshake -> IDLE, frame_count not incremented. start coincident with abort -> stays IDLE.
6. Assert rst_n low mid-FILL -> all outputs reach reset values immediately (asynchronously). frame_count=0. Run 65537 frames with CNT_W=16 -> frame_count wraps to 1.
